ama_riscv_alu_mc: RTL and testbench



---
 rtl/ama_riscv_alu_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_ama_riscv_alu_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_alu_mc
// Description : Multi-cycle RV32/64 ALU with RV32M multiply/divide behind a
//               valid/ready handshake. ALU_MC_MUL_FAST_EN selects a
//               single-cycle multiplier in place of the iterative one.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op_sel,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_s,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [SHW-1:0]  CNT_INIT = SHW'(XLEN-1);

`ifdef ALU_MC_MUL_FAST_EN
    localparam bit MUL_FAST = 1'b1;
`else
    localparam bit MUL_FAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [SHW-1:0]      cnt;
    logic                is_div;
    logic                hi_sel;
    logic                neg_res;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     quo;

    // Request decode, evaluated against the live inputs in IDLE
    logic [SHW-1:0]      sh;
    logic [XLEN-1:0]     base_res;
    logic                a_sgn, b_sgn, neg_a, neg_b;
    logic [XLEN-1:0]     mag_a_in, mag_b_in;
    logic                is_mul_in, is_div_in, hi_sel_in, neg_res_in;
    logic                div_zero, div_ovf, goes_busy;
    logic [XLEN-1:0]     fast_res;
`ifdef ALU_MC_MUL_FAST_EN
    logic [2*XLEN-1:0]   fast_full;
    logic [2*XLEN-1:0]   fast_fix;
`endif

    always_comb begin
        sh       = in_b[SHW-1:0];
        base_res = '0;
        case (op_sel[3:0])
            ALU_ADD:    base_res = in_a + in_b;
            ALU_SUB:    base_res = in_a - in_b;
            ALU_SLL:    base_res = in_a << sh;
            ALU_SLT:    base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_SLTU:   base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            ALU_XOR:    base_res = in_a ^ in_b;
            ALU_SRL:    base_res = in_a >> sh;
            ALU_SRA:    base_res = $unsigned($signed(in_a) >>> sh);
            ALU_OR:     base_res = in_a | in_b;
            ALU_AND:    base_res = in_a & in_b;
            ALU_PASS_B: base_res = in_b;
            default:    base_res = '0;
        endcase

        is_mul_in = (op_sel[4:3] == 2'b10) && !op_sel[2];
        is_div_in = (op_sel[4:3] == 2'b10) &&  op_sel[2];

        // Signedness per M-op: MULH, MULHSU (A only), DIV, REM
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op_sel[2:0])
            3'd1:       begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'd2:       a_sgn = 1'b1;
            3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:    ;
        endcase
        neg_a    = a_sgn & in_a[XLEN-1];
        neg_b    = b_sgn & in_b[XLEN-1];
        mag_a_in = neg_a ? -in_a : in_a;
        mag_b_in = neg_b ? -in_b : in_b;

        hi_sel_in  = is_mul_in ? (op_sel[1:0] != 2'b00) : op_sel[1];
        neg_res_in = (is_div_in && op_sel[1]) ? neg_a : (neg_a ^ neg_b);

        div_zero  = (in_b == '0);
        div_ovf   = !op_sel[0] && (in_a == MIN_NEG) && (in_b == ALL_ONES);
        goes_busy = (is_div_in && !div_zero && !div_ovf) || (is_mul_in && !MUL_FAST);

        fast_res = '0;
        if (!op_sel[4]) begin
            fast_res = base_res;
        end else if (is_div_in && div_zero) begin
            fast_res = op_sel[1] ? in_a : ALL_ONES;
        end else if (is_div_in && div_ovf) begin
            fast_res = op_sel[1] ? '0 : in_a;
        end
`ifdef ALU_MC_MUL_FAST_EN
        fast_full = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
        fast_fix  = neg_res_in ? -fast_full : fast_full;
        if (is_mul_in) begin
            fast_res = hi_sel_in ? fast_fix[2*XLEN-1:XLEN] : fast_fix[XLEN-1:0];
        end
`endif
    end

    // One shift-add / restoring-divide step per BUSY cycle
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_nxt, prod_fix;
    logic [XLEN:0]       div_shift, div_diff;
    logic                div_ge;
    logic [XLEN-1:0]     rem_nxt, quo_nxt, q_fix, r_fix, iter_res;

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
        prod_nxt  = {mul_sum, prod[XLEN-1:1]};
        prod_fix  = neg_res ? -prod_nxt : prod_nxt;

        div_shift = {rem, quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = !div_diff[XLEN];
        rem_nxt   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_nxt   = {quo[XLEN-2:0], div_ge};
        q_fix     = neg_res ? -quo_nxt : quo_nxt;
        r_fix     = neg_res ? -rem_nxt : rem_nxt;

        if (is_div) begin
            iter_res = hi_sel ? r_fix : q_fix;
        end else begin
            iter_res = hi_sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_s   <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            hi_sel  <= 1'b0;
            neg_res <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
        end else if (flush) begin
            state <= IDLE;
            out_s <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_div  <= is_div_in;
                        hi_sel  <= hi_sel_in;
                        neg_res <= neg_res_in;
                        mag_a   <= mag_a_in;
                        mag_b   <= mag_b_in;
                        prod    <= {{XLEN{1'b0}}, mag_b_in};
                        rem     <= '0;
                        quo     <= mag_a_in;
                        cnt     <= CNT_INIT;
                        if (goes_busy) begin
                            state <= BUSY;
                        end else begin
                            state <= DONE;
                            out_s <= fast_res;
                        end
                    end
                end
                BUSY: begin
                    prod <= prod_nxt;
                    rem  <= rem_nxt;
                    quo  <= quo_nxt;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == '0) begin
                        state <= DONE;
                        out_s <= iter_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_alu_mc
// Description : Self-checking bench for ama_riscv_alu_mc (XLEN=32), directed
//               cases plus random ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_alu_mc;

    localparam int XLEN = 32;

`ifdef ALU_MC_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd8,  OP_SLL = 5'd1,  OP_SLT = 5'd2;
    localparam logic [4:0] OP_SLTU = 5'd3, OP_XOR = 5'd4,  OP_SRL = 5'd5,  OP_SRA = 5'd13;
    localparam logic [4:0] OP_OR = 5'd6,   OP_AND = 5'd7,  OP_PASSB = 5'd15;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,    OP_REMU = 5'd23;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op_sel = '0;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_s;
    logic            busy;

    int errors = 0;
    int checks = 0;

    ama_riscv_alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_SLL:    return a << b[4:0];
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    return a ^ b;
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return sa >>> b[4:0];
            OP_OR:     return a | b;
            OP_AND:    return a & b;
            OP_PASSB:  return b;
            OP_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            OP_MULH:   begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            OP_MULHSU: begin sp = longint'(sa) * longint'({32'd0, b}); return sp[63:32]; end
            OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd16 || op > 5'd23) return 1;
        if (op < 5'd20) return MUL_LAT;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, scramble the inputs after accept, wait for the
    // result and pop it with a single out_ready pulse.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] expv;
        expv    = ref_model(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        op_sel    = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_sel   = 5'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_out_s"}, out_s, expv);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    logic [4:0] op_list [21] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                                 OP_SRA, OP_OR, OP_AND, OP_PASSB, 5'd9, 5'd25,
                                 OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                 OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    initial begin
        int          lat;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {in_ready, out_valid, busy, out_s}, {3'b100, 32'd0});

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'd2, "mulh");
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2, "mulhu");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(OP_DIVU, 32'd7, 32'd0, "divu_zero");
        run_op(OP_REMU, 32'd7, 32'd0, "remu_zero");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        run_op(OP_SRA, 32'h8000_0010, 32'h0000_0024, "sra_shamt");

        // Backpressure: result must sit still while out_ready is low
        @(negedge clk);
        op_sel = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check("bp_latency", lat, XLEN + 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid, in_ready, out_s}, {2'b10, 32'd14});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);

        // flush and in_valid together in IDLE: nothing is accepted
        @(negedge clk);
        op_sel = OP_ADD; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle", {in_ready, out_valid, busy}, 3'b100);
        @(negedge clk);
        check("flush_idle_late", out_valid, 1'b0);

        // flush ten cycles into a DIV, then MUL 3*5
        @(negedge clk);
        op_sel = OP_DIV; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", {in_ready, out_valid, busy}, 3'b100);
        run_op(OP_MUL, 32'd3, 32'd5, "mul_after_flush");

        // rst in the middle of a MUL
        @(negedge clk);
        op_sel = OP_MUL; in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mul", {in_ready, out_valid, busy, out_s}, {3'b100, 32'd0});
        run_op(OP_MUL, 32'd7, 32'd9, "mul_after_rst");

        for (int n = 0; n < 60; n++) begin
            rop = op_list[$urandom_range(0, 20)];
            ra  = rand_operand();
            rb  = rand_operand();
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
